// File: rtl/cpu_boot_loader_pkg.sv
// Shared definitions for the CPU boot loader: state encoding, word
// geometry and the CPU address width shared with the CPU core.
package cpu_boot_loader_pkg;

   // Address width of the CPU core's RAM bus.
   localparam int CPU_ADDR_W     = 14;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/cpu_boot_loader_if.sv
// Bus bundle of the boot loader: byte-loader handshake, CPU-side RAM
// request, RAM port, CPU reset and loader status.
//
// Loader handshake: a byte transfers on a rising edge of clk where
// ld_valid && ld_ready. ld_ready is a function of loader state only
// (never of ld_valid). A source holds ld_byte/ld_last stable while
// ld_valid is high and the byte has not yet transferred.
interface cpu_boot_loader_if #(
   parameter int SIZE = cpu_boot_loader_pkg::CPU_ADDR_W
);
   logic                          ld_valid;
   logic                          ld_ready;
   logic [7:0]                    ld_byte;
   logic                          ld_last;
   logic                          cpu_wrEn;
   logic [SIZE-1:0]               cpu_addr;
   logic [31:0]                   cpu_data;
   logic                          cpu_rst;
   logic                          ram_wrEn;
   logic [SIZE-1:0]               ram_addr;
   logic [31:0]                   ram_data;
   logic                          busy;
   logic                          load_err;
   logic [SIZE:0]                 word_count;
   cpu_boot_loader_pkg::state_t   state_dbg;

   // The boot loader itself.
   modport slave (
      input  ld_valid, ld_byte, ld_last, cpu_wrEn, cpu_addr, cpu_data,
      output ld_ready, cpu_rst, ram_wrEn, ram_addr, ram_data, busy,
      output load_err, word_count, state_dbg
   );

   // Host side: byte source, CPU and RAM observers.
   modport master (
      output ld_valid, ld_byte, ld_last, cpu_wrEn, cpu_addr, cpu_data,
      input  ld_ready, cpu_rst, ram_wrEn, ram_addr, ram_data, busy,
      input  load_err, word_count, state_dbg
   );

endinterface

// File: rtl/cpu_boot_loader_byte_word_packer.sv
// byte_word_packer: packs accepted bytes big-endian into 32-bit words.
// The first byte of a word lands in bits 31:24. A byte flagged last
// closes the word early with the remaining low bytes zero. word_valid
// is high in the cycle whose closing edge completes a word; word_data
// holds that word from the completing edge until the next one.
module byte_word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   input  logic        last_in,
   output logic        word_valid,
   output logic [31:0] word_data
);

   logic [1:0]  idx_q;
   logic [31:0] asm_q;
   logic [31:0] asm_next;

   // Place the incoming byte into its lane and detect word completion.
   always_comb begin
      asm_next = asm_q;
      case (idx_q)
         2'd0:    asm_next[31:24] = byte_in;
         2'd1:    asm_next[23:16] = byte_in;
         2'd2:    asm_next[15:8]  = byte_in;
         default: asm_next[7:0]   = byte_in;
      endcase
      word_valid = byte_en && ((idx_q == 2'd3) || last_in);
   end

   // Assembly register, byte index and completed-word register.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= 2'd0;
         asm_q     <= 32'd0;
         word_data <= 32'd0;
      end else if (clear) begin
         idx_q <= 2'd0;
         asm_q <= 32'd0;
      end else if (byte_en) begin
         if (word_valid) begin
            word_data <= asm_next;
            asm_q     <= 32'd0;
            idx_q     <= 2'd0;
         end else begin
            asm_q <= asm_next;
            idx_q <= idx_q + 2'd1;
         end
      end
   end

endmodule

// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader: holds the CPU in reset while a byte-serial program
// image is written into RAM from word 0, waits SETTLE_CYCLES after the
// final write, then hands the RAM port to the CPU and releases it.
// Optional feature: define LOADER_RELOAD_EN to add a `reload` input
// that sends a running system back into LOAD.
module cpu_boot_loader
   import cpu_boot_loader_pkg::*;
#(
   parameter int SIZE          = CPU_ADDR_W,
   parameter int DEPTH         = 16384,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
`ifdef LOADER_RELOAD_EN
   input  logic             reload,
`endif
   cpu_boot_loader_if.slave bus
);

   localparam int            SW      = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SIZE:0] DEPTH_W = (SIZE + 1)'(DEPTH);

   state_t          state_q;
   state_t          state_d;
   logic [SIZE:0]   wc_q;
   logic [SIZE-1:0] addr_q;
   logic            wr_q;
   logic            err_q;
   logic [SW-1:0]   settle_q;
   logic            ld_ready;
   logic            accept;
   logic            word_valid;
   logic [31:0]     word_data;
   logic            reload_req;
   logic            image_done;
   logic            ram_full;

`ifdef LOADER_RELOAD_EN
   assign reload_req = (state_q == RUN) && reload;
`else
   assign reload_req = 1'b0;
`endif

   assign ld_ready   = (state_q == LOAD);
   assign accept     = bus.ld_valid && ld_ready;
   assign image_done = accept && bus.ld_last;
   assign ram_full   = (wc_q == DEPTH_W);

   byte_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (reload_req),
      .byte_en    (accept),
      .byte_in    (bus.ld_byte),
      .last_in    (bus.ld_last),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= LOAD;
      else     state_q <= state_d;
   end

   // Next state: LOAD until the last byte, HOLD for the settle count, RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (image_done) state_d = HOLD;
         HOLD:    if (settle_q == '0) state_d = RUN;
         RUN:     if (reload_req) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // Loader write port, word counter, overflow flag and settle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wc_q     <= '0;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         settle_q <= '0;
      end else begin
         wr_q <= 1'b0;
         if (image_done)
            settle_q <= SW'(SETTLE_CYCLES);
         else if ((state_q == HOLD) && (settle_q != '0))
            settle_q <= settle_q - SW'(1);
         // Words beyond DEPTH are dropped but the stream keeps flowing.
         if (word_valid) begin
            if (ram_full) begin
               err_q <= 1'b1;
            end else begin
               wr_q   <= 1'b1;
               addr_q <= wc_q[SIZE-1:0];
               wc_q   <= wc_q + (SIZE + 1)'(1);
            end
         end
         if (reload_req) begin
            wc_q  <= '0;
            err_q <= 1'b0;
         end
      end
   end

   // RAM port mux and status: the CPU reaches RAM only in RUN, unregistered.
   always_comb begin
      bus.ram_wrEn = wr_q;
      bus.ram_addr = addr_q;
      bus.ram_data = word_data;
      if (state_q == RUN) begin
         bus.ram_wrEn = bus.cpu_wrEn;
         bus.ram_addr = bus.cpu_addr;
         bus.ram_data = bus.cpu_data;
      end
      bus.ld_ready   = ld_ready;
      bus.cpu_rst    = (state_q != RUN);
      bus.busy       = (state_q != RUN);
      bus.load_err   = err_q;
      bus.word_count = wc_q;
      bus.state_dbg  = state_q;
   end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Bench for cpu_boot_loader: two instances (full depth, and DEPTH=4 with a
// longer settle) share one byte stream; each is compared against a model
// that derives RAM writes, write edges and release edge from the image.
module tb_cpu_boot_loader;
   import cpu_boot_loader_pkg::*;

   localparam int SIZE    = 14;
   localparam int DEPTH0  = 16384;
   localparam int SETTLE0 = 2;
   localparam int DEPTH1  = 4;
   localparam int SETTLE1 = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            ld_valid = 1'b0;
   logic            ld_last  = 1'b0;
   logic [7:0]      ld_byte  = 8'd0;
   logic            cpu_wrEn = 1'b0;
   logic [SIZE-1:0] cpu_addr = '0;
   logic [31:0]     cpu_data = 32'd0;
`ifdef LOADER_RELOAD_EN
   logic            reload = 1'b0;
`endif

   cpu_boot_loader_if #(.SIZE(SIZE)) bus0 ();
   cpu_boot_loader_if #(.SIZE(SIZE)) bus1 ();

   assign bus0.ld_valid = ld_valid;
   assign bus0.ld_byte  = ld_byte;
   assign bus0.ld_last  = ld_last;
   assign bus0.cpu_wrEn = cpu_wrEn;
   assign bus0.cpu_addr = cpu_addr;
   assign bus0.cpu_data = cpu_data;
   assign bus1.ld_valid = ld_valid;
   assign bus1.ld_byte  = ld_byte;
   assign bus1.ld_last  = ld_last;
   assign bus1.cpu_wrEn = cpu_wrEn;
   assign bus1.cpu_addr = cpu_addr;
   assign bus1.cpu_data = cpu_data;

   cpu_boot_loader #(.SIZE(SIZE), .DEPTH(DEPTH0), .SETTLE_CYCLES(SETTLE0)) dut0 (
      .clk    (clk),
      .rst    (rst),
`ifdef LOADER_RELOAD_EN
      .reload (reload),
`endif
      .bus    (bus0)
   );

   cpu_boot_loader #(.SIZE(SIZE), .DEPTH(DEPTH1), .SETTLE_CYCLES(SETTLE1)) dut1 (
      .clk    (clk),
      .rst    (rst),
`ifdef LOADER_RELOAD_EN
      .reload (reload),
`endif
      .bus    (bus1)
   );

   // Clock and edge counter.
   always #5 clk = ~clk;
   int edge_cnt = 0;
   always @(posedge clk) edge_cnt++;

   // Scoreboard state.
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  img[$];
   int          acc[$];
   logic [45:0] obs_q0[$];
   logic [45:0] obs_q1[$];
   int          obs_e0[$];
   int          obs_e1[$];
   int          fall_e0 = -1;
   int          fall_e1 = -1;
   logic        prev0 = 1'b1;
   logic        prev1 = 1'b1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Monitor: loader-side RAM writes and the CPU reset release edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus0.ram_wrEn && bus0.busy) begin
            obs_q0.push_back({bus0.ram_addr, bus0.ram_data});
            obs_e0.push_back(edge_cnt);
         end
         if (bus1.ram_wrEn && bus1.busy) begin
            obs_q1.push_back({bus1.ram_addr, bus1.ram_data});
            obs_e1.push_back(edge_cnt);
         end
         if (prev0 && !bus0.cpu_rst && fall_e0 < 0) fall_e0 = edge_cnt;
         if (prev1 && !bus1.cpu_rst && fall_e1 < 0) fall_e1 = edge_cnt;
         prev0 = bus0.cpu_rst;
         prev1 = bus1.cpu_rst;
      end
   end

   task automatic clear_scoreboard();
      obs_q0.delete(); obs_q1.delete();
      obs_e0.delete(); obs_e1.delete();
      img.delete(); acc.delete();
      fall_e0 = -1; fall_e1 = -1;
   endtask

   task automatic check_reset_vals(input int inst, input string ctx);
      cpu_boot_loader_pkg::state_t st;
      logic [63:0] v [8];
      if (inst == 0) begin
         v[0] = 64'(bus0.cpu_rst);  v[1] = 64'(bus0.ld_ready);  v[2] = 64'(bus0.ram_wrEn);
         v[3] = 64'(bus0.ram_addr); v[4] = 64'(bus0.ram_data);  v[5] = 64'(bus0.load_err);
         v[6] = 64'(bus0.word_count); v[7] = 64'(bus0.busy); st = bus0.state_dbg;
      end else begin
         v[0] = 64'(bus1.cpu_rst);  v[1] = 64'(bus1.ld_ready);  v[2] = 64'(bus1.ram_wrEn);
         v[3] = 64'(bus1.ram_addr); v[4] = 64'(bus1.ram_data);  v[5] = 64'(bus1.load_err);
         v[6] = 64'(bus1.word_count); v[7] = 64'(bus1.busy); st = bus1.state_dbg;
      end
      check_eq($sformatf("%s_u%0d_cpu_rst", ctx, inst), v[0], 64'd1);
      check_eq($sformatf("%s_u%0d_ld_ready", ctx, inst), v[1], 64'd1);
      check_eq($sformatf("%s_u%0d_ram_wrEn", ctx, inst), v[2], 64'd0);
      if (ctx == "rst") begin
         check_eq($sformatf("%s_u%0d_ram_addr", ctx, inst), v[3], 64'd0);
         check_eq($sformatf("%s_u%0d_ram_data", ctx, inst), v[4], 64'd0);
      end
      check_eq($sformatf("%s_u%0d_load_err", ctx, inst), v[5], 64'd0);
      check_eq($sformatf("%s_u%0d_word_count", ctx, inst), v[6], 64'd0);
      check_eq($sformatf("%s_u%0d_busy", ctx, inst), v[7], 64'd1);
      check_eq($sformatf("%s_u%0d_state", ctx, inst), 64'(st), 64'(LOAD));
   endtask

   // Reset with the CPU driving a live write, so nothing of it may leak.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0;
      cpu_wrEn = 1'b1; cpu_addr = 14'($urandom_range(1, 16383)); cpu_data = $urandom | 32'h1;
      @(posedge clk); #1;
      clear_scoreboard();
      @(negedge clk);
      check_reset_vals(0, "rst");
      check_reset_vals(1, "rst");
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      bit done = 0;
      int guard = 0;
      while (!done && guard < 200) begin
         @(negedge clk);
         guard++;
         if ($urandom_range(0, 3) == 0) begin
            ld_valid = 1'b0;
            ld_byte  = 8'($urandom);
            ld_last  = 1'($urandom);
         end else begin
            ld_valid = 1'b1; ld_byte = b; ld_last = last;
            if (bus0.ld_ready) begin
               done = 1;
               acc.push_back(edge_cnt + 1);
            end
         end
      end
      if (!done) check_eq("ld_ready_wait", 64'(bus0.ld_ready), 64'd1);
   endtask

   task automatic send_img();
      for (int i = 0; i < img.size(); i++) send_byte(img[i], i == img.size() - 1);
   endtask

   task automatic wait_run();
      int n = 0;
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0;
      while ((bus0.busy || bus1.busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      #1;
      check_eq("run_reached", 64'(bus0.busy || bus1.busy), 64'd0);
   endtask

   // Reference: pad the image to whole words, pack big-endian, keep the
   // first DEPTH words; each write shows up at the edge taking its closing
   // byte; release comes SETTLE+1 edges after the final byte.
   task automatic check_load(input int inst);
      logic [45:0] exp_q[$];
      int          exp_e[$];
      logic [45:0] got_q[$];
      int          got_e[$];
      logic [45:0] w;
      int          depth, settle, nw, nexp, fall, li;
      logic [63:0] wc, err;
      if (inst == 0) begin
         depth = DEPTH0; settle = SETTLE0; got_q = obs_q0; got_e = obs_e0; fall = fall_e0;
         wc = 64'(bus0.word_count); err = 64'(bus0.load_err);
      end else begin
         depth = DEPTH1; settle = SETTLE1; got_q = obs_q1; got_e = obs_e1; fall = fall_e1;
         wc = 64'(bus1.word_count); err = 64'(bus1.load_err);
      end
      nw   = (img.size() + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
      nexp = (nw < depth) ? nw : depth;
      for (int k = 0; k < nexp; k++) begin
         w = '0;
         w[45:32] = 14'(k);
         for (int j = 0; j < BYTES_PER_WORD; j++)
            if (4 * k + j < img.size()) w[31 - 8 * j -: 8] = img[4 * k + j];
         exp_q.push_back(w);
         li = 4 * k + 3;
         if (li >= img.size()) li = img.size() - 1;
         exp_e.push_back(acc[li]);
      end
      check_eq($sformatf("u%0d_num_writes", inst), 64'(got_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         check_eq($sformatf("u%0d_write%0d_addr_data", inst, k), 64'(got_q[k]), 64'(exp_q[k]));
         check_eq($sformatf("u%0d_write%0d_edge", inst, k), 64'(got_e[k]), 64'(exp_e[k]));
      end
      check_eq($sformatf("u%0d_word_count", inst), wc, 64'(nexp));
      check_eq($sformatf("u%0d_load_err", inst), err, 64'(nw > depth));
      check_eq($sformatf("u%0d_release_edge", inst), 64'(fall), 64'(acc[acc.size() - 1] + settle + 1));
   endtask

   task automatic run_image();
      send_img();
      wait_run();
      check_load(0);
      check_load(1);
   endtask

   task automatic check_passthrough(input logic we, input logic [SIZE-1:0] a, input logic [31:0] d);
      @(negedge clk);
      cpu_wrEn = we; cpu_addr = a; cpu_data = d;
      #1;
      check_eq("u0_pass_wrEn", 64'(bus0.ram_wrEn), 64'(we));
      check_eq("u0_pass_addr", 64'(bus0.ram_addr), 64'(a));
      check_eq("u0_pass_data", 64'(bus0.ram_data), 64'(d));
      check_eq("u1_pass_wrEn", 64'(bus1.ram_wrEn), 64'(we));
      check_eq("u1_pass_addr", 64'(bus1.ram_addr), 64'(a));
      check_eq("u1_pass_data", 64'(bus1.ram_data), 64'(d));
   endtask

   // Bytes offered while running must be refused and change nothing.
   task automatic poke_while_run();
      logic [63:0] wc0, wc1;
      wc0 = 64'(bus0.word_count);
      wc1 = 64'(bus1.word_count);
      repeat (4) begin
         @(negedge clk);
         ld_valid = 1'b1; ld_byte = 8'($urandom); ld_last = 1'($urandom);
         #1;
         check_eq("run_u0_ld_ready", 64'(bus0.ld_ready), 64'd0);
         check_eq("run_u1_ld_ready", 64'(bus1.ld_ready), 64'd0);
         check_eq("run_u0_cpu_rst", 64'(bus0.cpu_rst), 64'd0);
      end
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0;
      check_eq("run_u0_word_count_kept", 64'(bus0.word_count), wc0);
      check_eq("run_u1_word_count_kept", 64'(bus1.word_count), wc1);
      check_eq("run_u1_busy", 64'(bus1.busy), 64'd0);
   endtask

   initial begin
      // Image 01..08.
      do_reset();
      for (int i = 1; i <= 8; i++) img.push_back(8'(i));
      run_image();

      // CPU owns the RAM port in RUN.
      check_passthrough(1'b1, 14'h0005, 32'hDEADBEEF);
      for (int i = 0; i < 3; i++)
         check_passthrough(1'($urandom), 14'($urandom), $urandom);
      check_passthrough(1'b0, 14'h0000, 32'h0);
      poke_while_run();

      // Short final word padded with zeros.
      do_reset();
      img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      run_image();

      // 24 bytes overflows the DEPTH=4 instance.
      do_reset();
      for (int i = 0; i < 24; i++) img.push_back(8'($urandom));
      run_image();
      cpu_wrEn = 1'b0;

`ifdef LOADER_RELOAD_EN
      // Reload from RUN clears status and loads a fresh image at word 0.
      @(negedge clk);
      clear_scoreboard();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      #1;
      check_reset_vals(0, "reload");
      check_reset_vals(1, "reload");
      cpu_wrEn = 1'b1; cpu_addr = 14'h0007; cpu_data = 32'hCAFEF00D;
      for (int i = 0; i < 4; i++) img.push_back(8'($urandom));
      run_image();
      cpu_wrEn = 1'b0;
`endif

      // Reset in the middle of a load discards the partial word.
      do_reset();
      for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
      do_reset();
      img = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_image();

      // Random image lengths around both word and DEPTH boundaries.
      repeat (5) begin
         do_reset();
         for (int i = 0; i < $urandom_range(1, 24); i++) img.push_back(8'($urandom));
         run_image();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
